// File: rtl/gng_pkg.sv
// Shared definitions for the Gaussian noise generator statistics monitor.
// Holds the sample format constants, the monitor state type and the
// accumulator width helpers used by the top and the datapath.
package gng_pkg;

   localparam int GNG_DW        = 16;
   localparam int GNG_FRAC      = 11;
   localparam int GNG_HIST_BINS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } gng_state_e;

   // Signed sum of 2^log2n samples of dw bits.
   function automatic int gng_sum_w(input int dw, input int log2n);
      return dw + log2n;
   endfunction

   // Unsigned sum of 2^log2n squares; one square fits in 2*dw-1 bits.
   function automatic int gng_sumsq_w(input int dw, input int log2n);
      return 2 * dw - 1 + log2n;
   endfunction

endpackage

// File: rtl/gng_stat_mon_if.sv
// Noise generator stream between generator (master) and monitor (slave):
// the monitor issues clock-enables, the generator returns valid samples.
interface gng_stat_mon_if #(
   parameter int DW = 16
);
   logic                 ce_out;
   logic                 valid_in;
   logic signed [DW-1:0] data_in;

   modport master (input ce_out, output valid_in, output data_in);
   modport slave  (output ce_out, input valid_in, input data_in);
endinterface

// File: rtl/gng_stat_acc.sv
// Two-stage statistics datapath: stage 1 registers the sample and its
// square, stage 2 updates sum, sum of squares, min and max.
// Optional histogram under macro GNG_STAT_HIST_EN (16 offset-binary bins).
module gng_stat_acc
   import gng_pkg::*;
#(
   parameter int DW     = GNG_DW,
   parameter int LOG2_N = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr,
   input  logic                                  in_vld,
   input  logic signed [DW-1:0]                  in_data,
   output logic signed [gng_sum_w(DW,LOG2_N)-1:0] sum_o,
   output logic [gng_sumsq_w(DW,LOG2_N)-1:0]      sumsq_o,
   output logic signed [DW-1:0]                  min_o,
   output logic signed [DW-1:0]                  max_o
`ifdef GNG_STAT_HIST_EN
   ,
   input  logic [3:0]                            hist_addr,
   output logic [LOG2_N:0]                       hist_data
`endif
);

   localparam int SUMW = gng_sum_w(DW, LOG2_N);
   localparam int SQW  = gng_sumsq_w(DW, LOG2_N);
   localparam logic signed [DW-1:0] MIN_INIT = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MAX_INIT = {1'b1, {(DW-1){1'b0}}};

   logic                 s1_vld_q, s1_vld_d;
   logic signed [DW-1:0] s1_data_q, s1_data_d;
   logic [2*DW-2:0]      s1_sq_q, s1_sq_d;
   logic [2*DW-2:0]      ext, prod;

   logic signed [SUMW-1:0] sum_q, sum_d;
   logic [SQW-1:0]         sumsq_q, sumsq_d;
   logic signed [DW-1:0]   min_q, min_d, max_q, max_d;

   // Stage 1: square in 2*DW-1 bits; modular product is exact since |x|^2 <= 2^(2*DW-2).
   always_comb begin
      ext       = {{(DW-1){in_data[DW-1]}}, in_data};
      prod      = ext * ext;
      s1_vld_d  = in_vld & ~clr;
      s1_data_d = in_data;
      s1_sq_d   = prod;
   end

   // Stage 2: accumulate, or reload the window start values on clear.
   always_comb begin
      sum_d   = sum_q;
      sumsq_d = sumsq_q;
      min_d   = min_q;
      max_d   = max_q;
      if (clr) begin
         sum_d   = '0;
         sumsq_d = '0;
         min_d   = MIN_INIT;
         max_d   = MAX_INIT;
      end else if (s1_vld_q) begin
         sum_d   = sum_q + {{LOG2_N{s1_data_q[DW-1]}}, s1_data_q};
         sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, s1_sq_q};
         if (s1_data_q < min_q) min_d = s1_data_q;
         if (s1_data_q > max_q) max_d = s1_data_q;
      end
   end

   // Pipeline and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_sq_q   <= '0;
         sum_q     <= '0;
         sumsq_q   <= '0;
         min_q     <= '0;
         max_q     <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
         s1_sq_q   <= s1_sq_d;
         sum_q     <= sum_d;
         sumsq_q   <= sumsq_d;
         min_q     <= min_d;
         max_q     <= max_d;
      end
   end

   assign sum_o   = sum_q;
   assign sumsq_o = sumsq_q;
   assign min_o   = min_q;
   assign max_o   = max_q;

`ifdef GNG_STAT_HIST_EN
   logic [3:0]      bin_idx;
   logic [LOG2_N:0] hist_bus [GNG_HIST_BINS];

   // Offset-binary bin: inverted sign then the next three magnitude bits.
   assign bin_idx = {~s1_data_q[DW-1], s1_data_q[DW-2:DW-4]};

   for (genvar gi = 0; gi < GNG_HIST_BINS; gi++) begin : g_bin
      logic [LOG2_N:0] cnt_q, cnt_d;

      // Bin counter: cleared with the window, bumped by stage-2 samples.
      always_comb begin
         cnt_d = cnt_q;
         if (clr)                                    cnt_d = '0;
         else if (s1_vld_q && (bin_idx == 4'(gi)))   cnt_d = cnt_q + (LOG2_N+1)'(1);
      end

      // Bin counter register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt_q <= '0;
         else     cnt_q <= cnt_d;
      end

      assign hist_bus[gi] = cnt_q;
   end

   assign hist_data = hist_bus[hist_addr];
`endif

endmodule

// File: rtl/gng_stat_mon.sv
// Statistics monitor for the Gaussian noise generator: requests 2^LOG2_N
// samples, collects them and reports sum, sum of squares, min and max.
// Optional histogram read port under macro GNG_STAT_HIST_EN.
module gng_stat_mon
   import gng_pkg::*;
#(
   parameter int LOG2_N = 16,
   parameter int DW     = GNG_DW
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   gng_stat_mon_if.slave                         gen,
   output logic                                  busy,
   output logic                                  done,
   output logic signed [gng_sum_w(DW,LOG2_N)-1:0] sum_out,
   output logic [gng_sumsq_w(DW,LOG2_N)-1:0]      sumsq_out,
   output logic signed [DW-1:0]                  min_out,
   output logic signed [DW-1:0]                  max_out
`ifdef GNG_STAT_HIST_EN
   ,
   input  logic [3:0]                            hist_addr,
   output logic [LOG2_N:0]                       hist_data
`endif
);

   localparam int CW   = LOG2_N + 1;
   localparam int SUMW = gng_sum_w(DW, LOG2_N);
   localparam int SQW  = gng_sumsq_w(DW, LOG2_N);
   localparam logic [CW-1:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

   gng_state_e      state_q, state_d;
   logic [CW-1:0]   req_cnt_q, req_cnt_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic            flush_q, flush_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            accept, acc_clr;

   logic signed [SUMW-1:0] sum_q, sum_d, acc_sum;
   logic [SQW-1:0]         sumsq_q, sumsq_d, acc_sumsq;
   logic signed [DW-1:0]   min_q, min_d, acc_min;
   logic signed [DW-1:0]   max_q, max_d, acc_max;

   gng_stat_acc #(.DW(DW), .LOG2_N(LOG2_N)) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .in_vld   (accept),
      .in_data  (gen.data_in),
      .sum_o    (acc_sum),
      .sumsq_o  (acc_sumsq),
      .min_o    (acc_min),
      .max_o    (acc_max)
`ifdef GNG_STAT_HIST_EN
      ,
      .hist_addr(hist_addr),
      .hist_data(hist_data)
`endif
   );

   // State, counters and result registers; reset aborts any run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_cnt_q <= '0;
         rx_cnt_q  <= '0;
         flush_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sum_q     <= '0;
         sumsq_q   <= '0;
         min_q     <= '0;
         max_q     <= '0;
      end else begin
         state_q   <= state_d;
         req_cnt_q <= req_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         flush_q   <= flush_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sum_q     <= sum_d;
         sumsq_q   <= sumsq_d;
         min_q     <= min_d;
         max_q     <= max_d;
      end
   end

   // Next state: FLUSH is entered on the edge that takes the Nth sample.
   always_comb begin
      state_d   = state_q;
      req_cnt_d = req_cnt_q;
      rx_cnt_d  = rx_cnt_q + {{LOG2_N{1'b0}}, accept};
      flush_d   = flush_q;
      acc_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               req_cnt_d = '0;
               rx_cnt_d  = '0;
               flush_d   = 1'b0;
               acc_clr   = 1'b1;
            end
         end
         RUN: begin
            req_cnt_d = req_cnt_q + CW'(1);
            if (req_cnt_d == N_CNT)
               state_d = (rx_cnt_d == N_CNT) ? FLUSH : DRAIN;
         end
         DRAIN: begin
            if (rx_cnt_d == N_CNT) state_d = FLUSH;
         end
         FLUSH: begin
            flush_d = ~flush_q;
            if (flush_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: clock-enable, sample acceptance, and end-of-run result capture.
   always_comb begin
      gen.ce_out = (state_q == RUN);
      accept     = ((state_q == RUN) || (state_q == DRAIN)) && gen.valid_in
                   && (rx_cnt_q < N_CNT);
      busy_d     = busy_q;
      done_d     = 1'b0;
      sum_d      = sum_q;
      sumsq_d    = sumsq_q;
      min_d      = min_q;
      max_d      = max_q;
      if ((state_q == IDLE) && start) busy_d = 1'b1;
      if ((state_q == FLUSH) && flush_q) begin
         busy_d  = 1'b0;
         done_d  = 1'b1;
         sum_d   = acc_sum;
         sumsq_d = acc_sumsq;
         min_d   = acc_min;
         max_d   = acc_max;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum_out   = sum_q;
   assign sumsq_out = sumsq_q;
   assign min_out   = min_q;
   assign max_out   = max_q;

endmodule

// File: tb/tb_gng_stat_mon.sv
// Bench for gng_stat_mon (LOG2_N=4): generator model with configurable
// latency, reference statistics computed from the accepted sample list.
module tb_gng_stat_mon;

   localparam int LOG2_N = 4;
   localparam int DW     = 16;
   localparam int N      = 16;
   localparam int SUMW   = DW + LOG2_N;
   localparam int SQW    = 2 * DW - 1 + LOG2_N;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, done;
   logic signed [SUMW-1:0] sum_out;
   logic [SQW-1:0]         sumsq_out;
   logic signed [DW-1:0]   min_out, max_out;
`ifdef GNG_STAT_HIST_EN
   logic [3:0]      hist_addr;
   logic [LOG2_N:0] hist_data;
`endif

   gng_stat_mon_if #(.DW(DW)) gen_if ();

   gng_stat_mon #(.LOG2_N(LOG2_N), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .gen      (gen_if.slave),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .sumsq_out(sumsq_out),
      .min_out  (min_out),
      .max_out  (max_out)
`ifdef GNG_STAT_HIST_EN
      ,
      .hist_addr(hist_addr),
      .hist_data(hist_data)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Results expected on the outputs right now (last completed window or reset).
   longint exp_sum = 0;
   longint exp_sq  = 0;
   longint exp_min = 0;
   longint exp_max = 0;
   int     hist_m[16];

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_hist(input string name);
`ifdef GNG_STAT_HIST_EN
      for (int a = 0; a < 16; a++) begin
         hist_addr = 4'(a);
         #1;
         check($sformatf("%s_hist%0d", name, a), hist_data, hist_m[a]);
      end
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   // One window: start at cycle 0, generator answers each ce after 'lat'
   // cycles, 'extras' spurious valids follow the last answer. Optional
   // second start at restart_at, optional reset after rst_after accepted samples.
   task automatic run_win(input string name, input int lat, input int mode,
                          input int extras, input int restart_at, input int rst_after);
      int     sched[$];
      int     req, vidx, acc_n, nth, done_cyc, ndone, cecnt, post, slot;
      bit     aborted;
      longint esum, esq, emin, emax;
      int     hm[16];
      logic signed [DW-1:0] d;
      req = 0; vidx = 0; acc_n = 0; nth = -1; done_cyc = -1; ndone = 0;
      cecnt = 0; post = 0; aborted = 0;
      esum = 0; esq = 0; emin = 32767; emax = -32768;
      for (int i = 0; i < 16; i++) hm[i] = 0;

      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (aborted) begin
            rst = 1'b0;
            post++;
            if (post >= 12) break;
            continue;
         end
         if (rst_after >= 0 && acc_n == rst_after) begin
            rst = 1'b1;
            start = 1'b0;
            gen_if.valid_in = 1'b0;
            #1;
            check({name, "_rst_sum"}, sum_out, 0);
            check({name, "_rst_sumsq"}, sumsq_out, 0);
            check({name, "_rst_min"}, min_out, 0);
            check({name, "_rst_max"}, max_out, 0);
            check({name, "_rst_ce"}, gen_if.ce_out, 0);
            check({name, "_rst_busy"}, busy, 0);
            aborted = 1;
            continue;
         end
         if (gen_if.ce_out === 1'b1) begin
            cecnt++;
            req++;
            sched.push_back(cyc + lat);
            if (req == N)
               for (int e = 1; e <= extras; e++) sched.push_back(cyc + lat + e);
         end
         if (cyc == 8) check({name, "_busy_mid"}, busy, 1);
         if (cyc == restart_at) begin
            check({name, "_held_sum"}, sum_out, exp_sum);
            check({name, "_held_max"}, max_out, exp_max);
         end
         start = (cyc == 0) || (cyc == restart_at);
         if (sched.size() > 0 && sched[0] == cyc) begin
            slot = sched.pop_front();
            case (mode)
               0:       d = 16'sh0800;
               1:       d = (vidx % 2 == 0) ? 16'sh7FFF : 16'sh8000;
               default: d = 16'($urandom);
            endcase
            vidx++;
            gen_if.valid_in = 1'b1;
            gen_if.data_in  = d;
            if (acc_n < N) begin
               acc_n++;
               esum += longint'(d);
               esq  += longint'(d) * longint'(d);
               if (longint'(d) < emin) emin = longint'(d);
               if (longint'(d) > emax) emax = longint'(d);
               hm[(d + 32768) / 4096]++;
               if (acc_n == N) nth = cyc;
            end
         end else begin
            gen_if.valid_in = 1'b0;
            gen_if.data_in  = 16'($urandom);
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 30) break;
      end
      gen_if.valid_in = 1'b0;
      start = 1'b0;
      rst   = 1'b0;

      if (aborted) begin
         check({name, "_no_done"}, ndone, 0);
         exp_sum = 0; exp_sq = 0; exp_min = 0; exp_max = 0;
         for (int i = 0; i < 16; i++) hist_m[i] = 0;
      end else begin
         check({name, "_done_at"}, done_cyc, nth + 3);
         check({name, "_done_cnt"}, ndone, 1);
         check({name, "_ce_cnt"}, cecnt, N);
         check({name, "_sum"}, sum_out, esum);
         check({name, "_sumsq"}, sumsq_out, esq);
         check({name, "_min"}, min_out, emin);
         check({name, "_max"}, max_out, emax);
         check({name, "_busy_end"}, busy, 0);
         exp_sum = esum; exp_sq = esq; exp_min = emin; exp_max = emax;
         for (int i = 0; i < 16; i++) hist_m[i] = hm[i];
      end
      check_hist(name);
      $display("run %s lat=%0d: sum=%0d sumsq=%0d min=%0d max=%0d done_cycles=%0d",
               name, lat, sum_out, sumsq_out, min_out, max_out, ndone);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      gen_if.valid_in = 1'b0;
      gen_if.data_in  = '0;
`ifdef GNG_STAT_HIST_EN
      hist_addr = '0;
`endif
      for (int i = 0; i < 16; i++) hist_m[i] = 0;
      repeat (3) @(negedge clk);
      check("reset_sum", sum_out, 0);
      check("reset_sumsq", sumsq_out, 0);
      check("reset_min", min_out, 0);
      check("reset_max", max_out, 0);
      check("reset_ce", gen_if.ce_out, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      run_win("const",       1, 0, 0, -1, -1);
      run_win("alt",         1, 1, 0, -1, -1);
      run_win("lat5_extra",  5, 0, 3, -1, -1);
      run_win("restart",     2, 2, 0,  8, -1);
      run_win("abort",       1, 0, 0, -1,  7);
      run_win("after_abort", 1, 0, 0, -1, -1);
      for (int r = 0; r < 3; r++)
         run_win($sformatf("rand%0d", r), int'($urandom_range(1, 6)), 2,
                 int'($urandom_range(0, 3)), -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
